// File: rtl/dsc_mul_sched_pkg.sv
// Shared types and helpers for the unary-multiplier scheduler.
// Optional watchdog is enabled by DSC_SCHED_WDOG_EN (see dsc_mul_sched).
package dsc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Extra RUN cycles allowed beyond the longest possible unary stream.
  localparam int WDOG_MARGIN = 8;

  function automatic int res_w(input int dw, input int ni);
    return dw * ni + 1;
  endfunction

endpackage

// File: rtl/dsc_mul_sched_if.sv
// Requester, multiplier and response signals of the scheduler.
// slave = scheduler side, master = fabric/multiplier side.
interface dsc_mul_sched_if #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int NUM_REQ    = 4
) ();
  import dsc_sched_pkg::*;

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int RES_W = res_w(DATA_WIDTH, NUM_INPUTS);

  logic [NUM_REQ-1:0]                                 req_valid;
  logic [NUM_REQ-1:0]                                 req_ready;
  logic [NUM_REQ-1:0][NUM_INPUTS-1:0][DATA_WIDTH-1:0] req_data;
  logic                                               mul_rst;
  logic                                               mul_en;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]              mul_data_in;
  logic [RES_W-1:0]                                   mul_data_out;
  logic                                               mul_done;
  logic                                               rsp_valid;
  logic                                               rsp_ready;
  logic [RES_W-1:0]                                   rsp_data;
  logic [ID_W-1:0]                                    rsp_id;
  logic                                               busy;

  modport slave (
    input  req_valid, req_data, mul_data_out, mul_done, rsp_ready,
    output req_ready, mul_rst, mul_en, mul_data_in, rsp_valid, rsp_data, rsp_id, busy
  );

  modport master (
    output req_valid, req_data, mul_data_out, mul_done, rsp_ready,
    input  req_ready, mul_rst, mul_en, mul_data_in, rsp_valid, rsp_data, rsp_id, busy
  );

endinterface

// File: rtl/dsc_mul_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
// The caller owns and advances the pointer.
module dsc_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx
);

  logic          w_found;
  logic [ID_W:0] w_sum;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, i_ptr} + (ID_W+1)'(i);
      // Explicit wrap so non-power-of-2 NUM_REQ returns to 0 after NUM_REQ-1.
      if (w_sum >= (ID_W+1)'(NUM_REQ)) w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      if (!w_found && i_req[w_sum[ID_W-1:0]]) begin
        w_found                  = 1'b1;
        o_grant[w_sum[ID_W-1:0]] = 1'b1;
        o_idx                    = w_sum[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dsc_mul_sched.sv
// Time-shares one unary multiplier between NUM_REQ requesters (round-robin).
// DSC_SCHED_WDOG_EN adds a RUN watchdog with sticky err/err_id outputs.
//
//  state | meaning
//  IDLE  | multiplier held clear; grant one requester and capture its operands
//  CLEAR | one cycle of multiplier clear with new operands (flushes stale done)
//  RUN   | multiplier enabled; wait for done (or watchdog expiry)
//  RESP  | result presented, held until rsp_ready
module dsc_mul_sched
  import dsc_sched_pkg::*;
#(
  parameter  int DATA_WIDTH = 5,
  parameter  int NUM_INPUTS = 2,
  parameter  int NUM_REQ    = 4,
  localparam int ID_W       = $clog2(NUM_REQ),
  localparam int RES_W      = res_w(DATA_WIDTH, NUM_INPUTS)
) (
  input  logic            clk,
  input  logic            rst,
  dsc_mul_sched_if.slave  bus
`ifdef DSC_SCHED_WDOG_EN
  ,
  output logic            err,
  output logic [ID_W-1:0] err_id
`endif
);

  state_e                                r_state, w_next;
  logic [ID_W-1:0]                       r_ptr, r_id, w_gnt_idx;
  logic [NUM_REQ-1:0]                    w_gnt;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] r_opnd;
  logic [RES_W-1:0]                      r_rsp_data;
  logic                                  w_take, w_fin, w_tmo;

  dsc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_gnt),
    .o_idx   (w_gnt_idx)
  );

`ifdef DSC_SCHED_WDOG_EN
  localparam int              WD_W    = DATA_WIDTH * NUM_INPUTS + 2;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(2**(DATA_WIDTH*NUM_INPUTS) + WDOG_MARGIN - 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            w_wd_tc;
  assign w_wd_tc = (r_wd_cnt == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.req_ready = '0;
    bus.mul_rst   = 1'b1;
    bus.mul_en    = 1'b0;
    bus.rsp_valid = 1'b0;
    w_take        = 1'b0;
    w_fin         = 1'b0;
    w_tmo         = 1'b0;
    case (r_state)
      IDLE: begin
        if ((|bus.req_valid) && !rst) begin
          bus.req_ready = w_gnt;
          w_take        = 1'b1;
          w_next        = CLEAR;
        end
      end
      CLEAR: w_next = RUN;
      RUN: begin
        bus.mul_rst = 1'b0;
        bus.mul_en  = 1'b1;
        if (bus.mul_done) begin
          w_fin  = 1'b1;
          w_next = RESP;
        end
`ifdef DSC_SCHED_WDOG_EN
        else if (w_wd_tc) begin
          w_tmo  = 1'b1;
          w_next = RESP;
        end
`endif
      end
      RESP: begin
        bus.mul_rst   = 1'b0;
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_id       <= '0;
      r_opnd     <= '0;
      r_rsp_data <= '0;
    end else begin
      if (w_take) begin
        r_opnd <= bus.req_data[w_gnt_idx];
        r_id   <= w_gnt_idx;
        r_ptr  <= (w_gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + ID_W'(1);
      end
      if (w_fin)      r_rsp_data <= bus.mul_data_out;
      else if (w_tmo) r_rsp_data <= '0;
    end
  end

`ifdef DSC_SCHED_WDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
      err      <= 1'b0;
      err_id   <= '0;
    end else begin
      if (r_state == CLEAR)                  r_wd_cnt <= WD_LOAD;
      else if (r_state == RUN && !w_wd_tc)   r_wd_cnt <= r_wd_cnt - WD_W'(1);
      if (w_tmo) begin
        err    <= 1'b1;
        err_id <= r_id;
      end
    end
  end
`endif

  assign bus.mul_data_in = r_opnd;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_id      = r_id;
  assign bus.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_dsc_mul_sched.sv
// Directed bench for dsc_mul_sched with a small fixed-latency multiplier model.
module tb_dsc_mul_sched;

  localparam int DW    = 3;
  localparam int NI    = 2;
  localparam int NR    = 4;
  localparam int ID_W  = 2;
  localparam int RES_W = DW * NI + 1;
  localparam int LAT   = 3;

  logic clk;
  logic rst;
  logic inj_done;
  logic model_off;
  int   n_checks;
  int   n_fail;

`ifdef DSC_SCHED_WDOG_EN
  logic            err;
  logic [ID_W-1:0] err_id;
`endif

  dsc_mul_sched_if #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_REQ(NR)) u_if ();

  dsc_mul_sched #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_REQ(NR)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
`ifdef DSC_SCHED_WDOG_EN
    ,
    .err    (err),
    .err_id (err_id)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Multiplier model: done rises LAT enabled cycles after clear, held until next clear.
  logic [3:0]       m_cnt;
  logic             m_done;
  logic [RES_W-1:0] m_out;

  always_ff @(posedge clk) begin
    if (u_if.mul_rst) begin
      m_cnt  <= '0;
      m_done <= 1'b0;
      m_out  <= '0;
    end else if (u_if.mul_en && !m_done) begin
      m_cnt <= m_cnt + 4'd1;
      if (m_cnt == 4'(LAT-1)) begin
        m_done <= 1'b1;
        m_out  <= RES_W'(u_if.mul_data_in[0]) * RES_W'(u_if.mul_data_in[1]);
      end
    end
  end

  assign u_if.mul_done     = (m_done & ~model_off) | inj_done;
  assign u_if.mul_data_out = m_out;

  typedef struct {
    logic [NR-1:0] mask;
    logic [NR-1:0] exp_rdy;
    int            exp_id;
    int            exp_prod;
  } vec_t;

  vec_t tbl [10];

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_ops(input int idx, input int a, input int b);
    u_if.req_data[idx][0] = DW'(a);
    u_if.req_data[idx][1] = DW'(b);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_req_ready"}, 32'(u_if.req_ready), 32'd0);
    check({nm, "_mul_rst"},   32'(u_if.mul_rst), 32'd1);
    check({nm, "_mul_en"},    32'(u_if.mul_en), 32'd0);
    check({nm, "_mul_data"},  32'(u_if.mul_data_in), 32'd0);
    check({nm, "_rsp_valid"}, 32'(u_if.rsp_valid), 32'd0);
    check({nm, "_rsp_data"},  32'(u_if.rsp_data), 32'd0);
    check({nm, "_rsp_id"},    32'(u_if.rsp_id), 32'd0);
    check({nm, "_busy"},      32'(u_if.busy), 32'd0);
`ifdef DSC_SCHED_WDOG_EN
    check({nm, "_err"},       32'(err), 32'd0);
`endif
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    #1;
  endtask

  // Grant, CLEAR, RUN, then wait for the response; leaves the bench at the first RESP cycle.
  task automatic do_op(input string nm, input logic [NR-1:0] mask, input logic [NR-1:0] exp_rdy,
                       input int exp_id, input int exp_prod, input logic inj);
    int n;
    u_if.req_valid = mask;
    inj_done       = inj;
    #1;
    check({nm, "_grant"}, 32'(u_if.req_ready), 32'(exp_rdy));
    tick;
    check({nm, "_clear"}, 32'({u_if.req_ready, u_if.mul_rst, u_if.mul_en, u_if.rsp_valid, u_if.busy}),
          32'b0000_1001);
    tick;
    inj_done = 1'b0;
    check({nm, "_run"}, 32'({u_if.req_ready, u_if.mul_rst, u_if.mul_en, u_if.busy}), 32'b0000_011);
    n = 2;
    while (!u_if.rsp_valid && n < 200) begin
      tick;
      n++;
    end
    check({nm, "_rsp_seen"}, 32'(u_if.rsp_valid), 32'd1);
    check({nm, "_latency"},  32'(n), 32'(LAT + 3));
    check({nm, "_rsp_id"},   32'(u_if.rsp_id), 32'(exp_id));
    check({nm, "_rsp_data"}, 32'(u_if.rsp_data), 32'(exp_prod));
  endtask

  initial begin
    logic bad;
    n_checks = 0;
    n_fail   = 0;
    rst            = 1'b1;
    inj_done       = 1'b0;
    model_off      = 1'b0;
    u_if.req_valid = '0;
    u_if.req_data  = '0;
    u_if.rsp_ready = 1'b0;

    // Operand set: products 2, 15, 42, 28
    set_ops(0, 1, 2);
    set_ops(1, 3, 5);
    set_ops(2, 6, 7);
    set_ops(3, 7, 4);

    tbl[0] = '{4'b1111, 4'b0001, 0, 2};
    tbl[1] = '{4'b1111, 4'b0010, 1, 15};
    tbl[2] = '{4'b1111, 4'b0100, 2, 42};
    tbl[3] = '{4'b1111, 4'b1000, 3, 28};
    tbl[4] = '{4'b1111, 4'b0001, 0, 2};
    tbl[5] = '{4'b0001, 4'b0001, 0, 2};
    tbl[6] = '{4'b1000, 4'b1000, 3, 28};
    tbl[7] = '{4'b0110, 4'b0010, 1, 15};
    tbl[8] = '{4'b0011, 4'b0001, 0, 2};
    tbl[9] = '{4'b1100, 4'b0100, 2, 42};

    tick;
    tick;
    check_reset_vals("reset");
    rst = 1'b0;
    #1;
    check_reset_vals("post_reset");

    // Single request {3,4} on requester 2
    set_ops(2, 3, 4);
    do_op("single", 4'b0100, 4'b0100, 2, 12, 1'b0);
    u_if.req_valid = '0;
    u_if.rsp_ready = 1'b1;
    tick;
    u_if.rsp_ready = 1'b0;
    check("single_idle_busy", 32'(u_if.busy), 32'd0);
    set_ops(2, 6, 7);

    // Round-robin table starting from pointer 0
    apply_reset;
    u_if.rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("rr%0d", i), tbl[i].mask, tbl[i].exp_rdy, tbl[i].exp_id, tbl[i].exp_prod, 1'b0);
      tick;
    end
    check("rr_back_idle", 32'(u_if.busy), 32'd0);

    // Response back-pressure: pointer is 3 after the table
    u_if.rsp_ready = 1'b0;
    do_op("hold", 4'b1111, 4'b1000, 3, 28, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick;
      check($sformatf("hold%0d", i),
            32'({u_if.rsp_valid, u_if.req_ready, u_if.rsp_id, u_if.rsp_data}),
            32'({1'b1, 4'b0000, 2'd3, 7'd28}));
    end
    u_if.rsp_ready = 1'b1;
    tick;
    u_if.req_valid = '0;

    // Reset during RUN; pointer would otherwise be 2
    u_if.req_valid = 4'b0010;
    tick;
    tick;
    tick;
    u_if.req_valid = '0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (u_if.rsp_valid || u_if.busy) bad = 1'b1;
    end
    check("abandoned_no_rsp", 32'(bad), 32'd0);
    do_op("after_rst", 4'b0101, 4'b0001, 0, 2, 1'b0);
    tick;
    u_if.req_valid = '0;

    // Edge operands with stale done across IDLE/CLEAR; pointer is 1
    set_ops(1, 7, 7);
    set_ops(2, 0, 7);
    do_op("edge49", 4'b0010, 4'b0010, 1, 49, 1'b1);
    tick;
    do_op("edge0", 4'b0100, 4'b0100, 2, 0, 1'b1);
    tick;
    u_if.req_valid = '0;

`ifdef DSC_SCHED_WDOG_EN
    begin
      int n;
      model_off      = 1'b1;
      u_if.req_valid = 4'b1000;
      #1;
      check("wdog_grant", 32'(u_if.req_ready), 32'b1000);
      tick;
      tick;
      u_if.req_valid = '0;
      n = 2;
      while (!u_if.rsp_valid && n < 300) begin
        tick;
        n++;
      end
      check("wdog_latency", 32'(n), 32'd74);
      check("wdog_err",     32'(err), 32'd1);
      check("wdog_err_id",  32'(err_id), 32'd3);
      check("wdog_rsp_id",  32'(u_if.rsp_id), 32'd3);
      check("wdog_rsp_data", 32'(u_if.rsp_data), 32'd0);
      tick;
      model_off = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
